icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache sitting between the core's instruction port
//  (i_addr/i_data) and a slow word-wide instruction memory with req/ack handshake.
//  Hits return data combinationally in the same cycle; misses assert cpu_stall, which gates the core's PC enable,
//  while the FILL state machine fetches the whole line. Supports a one-cycle invalidate-all.
// PARAMETERS
//  LINES      16   number of cache lines, power of 2, >=2
//  WORDS      4    32-bit words per line, power of 2, >=2
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   asynchronous, active-low; clears state immediately
//  cpu_addr   in   32  byte address of instruction, from core PC; [1:0] ignored
//  cpu_data   out  32  instruction word, valid when cpu_stall=0
//  cpu_stall  out  1   1 = cpu_data not valid; core must hold PC/cpu_addr stable
//  inv        in   1   invalidate all lines (sampled on clk)
//  mem_req    out  1   fetch request to instruction memory
//  mem_addr   out  32  word-aligned fetch address ([1:0]=0)
//  mem_ack    in   1   memory accepted req; mem_data valid this cycle
//  mem_data   in   32  fetched word
// BEHAVIOUR
//  Address split: off=cpu_addr[OB+1:2], idx=[IB+OB+1:OB+2], tag=rest; OB=log2(WORDS), IB=log2(LINES).
//  hit = valid[idx] && tag_ram[idx]==tag && state==IDLE; cpu_stall = !hit (combinational).
//  cpu_data = data_ram[idx][off] (combinational read); don't-care when stalled.
//  Reset (reset=0): state=IDLE, all valid=0, mem_req=0, mem_addr=0, word counter=0, poison=0.
//   Consequently cpu_stall=1 after reset until first fill completes.
//  FSM states: IDLE, FILL.
//   IDLE: on !hit (and inv=0) -> FILL next edge; latch line base {tag,idx,OB+2'b0}, cnt=0.
//   FILL: mem_req=1, mem_addr=base+4*cnt. On mem_ack: data_ram[idx][cnt]<=mem_data, cnt++.
//     mem_req stays high across words; mem_addr advances the cycle after each ack.
//     On ack with cnt==WORDS-1: write tag, set valid[idx]=!poison, -> IDLE; mem_req=0 next cycle.
//  Miss latency: line resident on edge of final ack; hit (stall=0) the following cycle.
//   With ack-on-first-cycle memory: miss detect cycle + WORDS cycles, then hit.
//  inv: clears all valid bits at edge. In IDLE, no fill starts that cycle. In FILL, fill runs
//   to completion (memory handshake never abandoned) but poison=1 so the line is left invalid;
//   poison cleared on entering IDLE. inv wins over fill-completion valid set in same cycle.
//  mem_ack while IDLE: ignored. cpu_addr must be stable during FILL (guaranteed by stall);
//   changes are not tracked - latched base is used.
//  Reset mid-FILL: abort immediately, mem_req=0; late acks ignored in IDLE.
//  Counter widths: cnt is OB bits, wraps naturally after final word; no overflow state.
// STRUCTURE
//  Shared include cpu32_defs.vh: `ICACHE_LINES/`ICACHE_WORDS defaults, FSM state encodings.
//  Sub-module icache_tag_ram: LINES x (tag,valid) array with async read, sync write,
//   single-cycle clear-all, async reset. Data array inline (LINES*WORDS x 32, async read).
// TESTING
//  1 Reset then cpu_addr=0x100, mem acks every cycle -> stall=1, mem_addr 0x100,0x104,0x108,0x10C; hit next cycle.
//  2 After T1, cpu_addr=0x108 -> stall=0 same cycle, cpu_data = word fetched from 0x108, no mem_req.
//  3 cpu_addr=0x500 (same idx as 0x100, tag differs) -> miss, refill, then 0x100 misses again.
//  4 ack delayed 3 cycles per word -> mem_req held, mem_addr stable until ack; hit after final ack.
//  5 inv pulse mid-FILL of 0x200 -> fill completes all 4 acks, line invalid, 0x200 re-missed.
//  6 reset=0 mid-FILL -> mem_req=0 asynchronously, valids cleared; stray ack ignored.

Source files
------------

// File: rtl/icache_dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm_pkg
//  Purpose  : Shared constants and types for the direct-mapped I-cache.
//             Holds the default geometry, the bus width and the fill FSM
//             state type used by the cache top level.
//  Contents : c_XLEN       - instruction/address bus width
//             c_LINES_DEF  - default number of cache lines
//             c_WORDS_DEF  - default number of 32-bit words per line
//             state_t      - fill state machine states
//  Revision : 1.0  initial release
// ============================================================================
package icache_dm_pkg;

  localparam int unsigned c_XLEN      = 32;
  localparam int unsigned c_LINES_DEF = 16;
  localparam int unsigned c_WORDS_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage : icache_dm_pkg
`default_nettype wire

// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm_if
//  Purpose  : Bundles the core-side instruction port and the memory-side
//             fetch handshake of the I-cache into one interface.
//  Ports    : cpu_addr  - byte address from the core PC ([1:0] ignored)
//             cpu_data  - instruction word, valid when cpu_stall is low
//             cpu_stall - high while cpu_data is not valid
//             inv       - invalidate-all request
//             mem_req   - fetch request to instruction memory
//             mem_addr  - word-aligned fetch address
//             mem_ack   - memory accepted request, mem_data valid
//             mem_data  - fetched instruction word
//  Modports : slave  - the cache's view
//             master - the environment's view (core plus memory)
//  Revision : 1.0  initial release
// ============================================================================
interface icache_dm_if;
  import icache_dm_pkg::*;

  logic [c_XLEN-1:0] cpu_addr;
  logic [c_XLEN-1:0] cpu_data;
  logic              cpu_stall;
  logic              inv;
  logic              mem_req;
  logic [c_XLEN-1:0] mem_addr;
  logic              mem_ack;
  logic [c_XLEN-1:0] mem_data;

  modport slave (
    input  cpu_addr,
    input  inv,
    input  mem_ack,
    input  mem_data,
    output cpu_data,
    output cpu_stall,
    output mem_req,
    output mem_addr
  );

  modport master (
    output cpu_addr,
    output inv,
    output mem_ack,
    output mem_data,
    input  cpu_data,
    input  cpu_stall,
    input  mem_req,
    input  mem_addr
  );

endinterface : icache_dm_if
`default_nettype wire

// File: rtl/icache_tag_ram.sv
`default_nettype none
// ============================================================================
//  Module   : icache_tag_ram
//  Purpose  : LINES x (tag, valid) store for the direct-mapped I-cache.
//             Asynchronous read, synchronous write, single-cycle clear of
//             every valid bit. Only the valid bits are reset; tag contents
//             are meaningless while their valid bit is clear.
//  Ports    : clk      - clock
//             reset    - asynchronous active-low reset
//             i_clr    - clear all valid bits (wins over a same-cycle write)
//             i_we     - write tag/valid at i_widx
//             i_widx   - write line index
//             i_wtag   - tag to write
//             i_wvalid - valid bit to write
//             i_ridx   - read line index
//             o_rtag   - tag stored at i_ridx
//             o_rvalid - valid bit at i_ridx
//  Revision : 1.0  initial release
// ============================================================================
module icache_tag_ram #(
  parameter int unsigned LINES = 16,
  parameter int unsigned TAG_W = 24
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     i_clr,
  input  wire logic                     i_we,
  input  wire logic [$clog2(LINES)-1:0] i_widx,
  input  wire logic [TAG_W-1:0]         i_wtag,
  input  wire logic                     i_wvalid,
  input  wire logic [$clog2(LINES)-1:0] i_ridx,
  output logic      [TAG_W-1:0]         o_rtag,
  output logic                          o_rvalid
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (i_clr) begin
      // Invalidate-all dominates a fill completing on the same edge.
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= i_wvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx] <= i_wtag;
    end
  end

  assign o_rtag   = r_tag[i_ridx];
  assign o_rvalid = r_valid[i_ridx];

endmodule : icache_tag_ram
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped, read-only instruction cache between the core's
//             instruction port and a slow word-wide memory with req/ack.
//             Hits return data combinationally in the same cycle. A miss
//             raises cpu_stall while the fill FSM fetches the whole line
//             one word per ack. inv clears every line in one cycle; an inv
//             during a fill lets the fill finish but leaves the line invalid.
//  Ports    : clk   - clock, all state updates on the rising edge
//             reset - asynchronous active-low reset
//             bus   - icache_dm_if.slave (core port + memory handshake)
//  Revision : 1.0  initial release
// ============================================================================
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned LINES = c_LINES_DEF,
  parameter int unsigned WORDS = c_WORDS_DEF
) (
  input wire logic  clk,
  input wire logic  reset,
  icache_dm_if.slave bus
);

  localparam int unsigned c_OB = $clog2(WORDS);
  localparam int unsigned c_IB = $clog2(LINES);
  localparam int unsigned c_TW = c_XLEN - c_IB - c_OB - 2;
  localparam logic [c_OB-1:0] c_LAST_WORD = c_OB'(WORDS - 1);

  // --------------------------------------------------------------------------
  // Address split
  // --------------------------------------------------------------------------
  logic [c_OB-1:0] w_off;
  logic [c_IB-1:0] w_idx;
  logic [c_TW-1:0] w_tag;
  logic            w_unused_byte;

  assign w_off         = bus.cpu_addr[c_OB+1:2];
  assign w_idx         = bus.cpu_addr[c_IB+c_OB+1:c_OB+2];
  assign w_tag         = bus.cpu_addr[c_XLEN-1:c_IB+c_OB+2];
  assign w_unused_byte = ^bus.cpu_addr[1:0];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_TW-1:0] r_tag;
  logic [c_IB-1:0] r_idx;
  logic [c_OB-1:0] r_cnt;
  logic            r_poison;

  logic            w_fill_start;
  logic            w_fill_word;
  logic            w_fill_last;

  // --------------------------------------------------------------------------
  // Tag / valid store
  // --------------------------------------------------------------------------
  logic [c_TW-1:0] w_rd_tag;
  logic            w_rd_valid;
  logic            w_hit;

  icache_tag_ram #(
    .LINES (LINES),
    .TAG_W (c_TW)
  ) u_tag_ram (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (bus.inv),
    .i_we     (w_fill_last),
    .i_widx   (r_idx),
    .i_wtag   (r_tag),
    .i_wvalid (!r_poison),
    .i_ridx   (w_idx),
    .o_rtag   (w_rd_tag),
    .o_rvalid (w_rd_valid)
  );

  // A hit is only reported in IDLE so the core never sees a line that is
  // being refilled underneath it.
  assign w_hit = w_rd_valid && (w_rd_tag == w_tag) && (r_state == ST_IDLE);

  // --------------------------------------------------------------------------
  // Data array: LINES*WORDS words, line-major, async read / sync write
  // --------------------------------------------------------------------------
  logic [c_XLEN-1:0] r_data [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (w_fill_word) begin
      r_data[{r_idx, r_cnt}] <= bus.mem_data;
    end
  end

  assign bus.cpu_data  = r_data[{w_idx, w_off}];
  assign bus.cpu_stall = !w_hit;

  // --------------------------------------------------------------------------
  // Fill FSM: next-state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_fill_start = 1'b0;
    w_fill_word  = 1'b0;
    w_fill_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An inv cycle never launches a fill, even on a miss.
        if (!w_hit && !bus.inv) begin
          w_fill_start = 1'b1;
          w_state_nxt  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.mem_ack) begin
          w_fill_word = 1'b1;
          if (r_cnt == c_LAST_WORD) begin
            w_fill_last = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fill FSM: registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_tag    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_poison <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fill_start) begin
        r_tag    <= w_tag;
        r_idx    <= w_idx;
        r_cnt    <= '0;
        r_poison <= 1'b0;
      end else if (r_state == ST_FILL) begin
        // cnt wraps back to zero after the final word.
        if (w_fill_word) begin
          r_cnt <= r_cnt + c_OB'(1);
        end
        // Poison only lives for the remainder of the current fill.
        if (w_fill_last) begin
          r_poison <= 1'b0;
        end else if (bus.inv) begin
          r_poison <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory side: address is derived from the latched base, so it moves
  // on the cycle after each ack and is zero outside a fill.
  // --------------------------------------------------------------------------
  assign bus.mem_req  = (r_state == ST_FILL);
  assign bus.mem_addr = (r_state == ST_FILL) ? {r_tag, r_idx, r_cnt, 2'b00} : '0;

endmodule : icache_dm
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Purpose  : Self-checking bench for icache_dm. Plays core and memory,
//             keeps a line-level model of which tags are resident, and
//             expects every word to equal a fixed function of its address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_dm;
  import icache_dm_pkg::*;

  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  icache_dm_if bus ();

  icache_dm #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: one entry per line, address bits [7:4] select the line, [31:8] tag.
  bit          m_valid [LINES];
  logic [23:0] m_tag   [LINES];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction fetch at address a, followed through any miss/refill.
  //  dly    : max random ack delay per word; negative = exact delay of -dly
  //  inv_at : fill cycle on which to pulse inv (-1 = never)
  //  rst_at : fill cycle on which to pulse reset (-1 = never)
  //  stray  : drive a spurious ack in the first (IDLE) cycle
  task automatic access(input logic [31:0] a, input int dly, input int inv_at,
                        input int rst_at, input bit stray);
    logic [31:0] base;
    bit poison;
    bit aborted;
    bit stray_now;
    int cyc;
    base      = {a[31:4], 4'h0};
    stray_now = stray;
    bus.cpu_addr = a;
    for (int attempt = 0; attempt < 5; attempt++) begin
      bus.mem_ack  = stray_now;
      bus.mem_data = 32'hDEAD_BEEF;
      stray_now    = 1'b0;
      #2;
      if (m_hit(a)) begin
        chk("hit_stall", 32'(bus.cpu_stall), 32'd0);
        chk("hit_data",  bus.cpu_data, memw({a[31:2], 2'b00}));
        chk("hit_noreq", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;
        tick();
        return;
      end
      chk("miss_stall", 32'(bus.cpu_stall), 32'd1);
      chk("miss_noreq", 32'(bus.mem_req), 32'd0);
      tick();
      bus.mem_ack = 1'b0;
      poison  = 1'b0;
      aborted = 1'b0;
      cyc     = 0;
      for (int w = 0; w < WORDS && !aborted; w++) begin
        int d;
        d = (dly < 0) ? -dly : int'($urandom_range(0, dly));
        for (int k = 0; k <= d && !aborted; k++) begin
          if (cyc == rst_at) begin
            #1 reset = 1'b0;
            #1;
            chk("rst_req",   32'(bus.mem_req), 32'd0);
            chk("rst_addr",  bus.mem_addr, 32'd0);
            chk("rst_stall", 32'(bus.cpu_stall), 32'd1);
            m_clear();
            bus.inv     = 1'b0;
            bus.mem_ack = 1'b0;
            tick();
            reset     = 1'b1;
            rst_at    = -1;
            aborted   = 1'b1;
            stray_now = 1'b1;
          end else begin
            bus.inv      = (cyc == inv_at);
            bus.mem_ack  = (k == d);
            bus.mem_data = (k == d) ? memw(base + 32'(4 * w)) : 32'hBAD0_0000 + 32'(cyc);
            #2;
            chk("fill_req",   32'(bus.mem_req), 32'd1);
            chk("fill_addr",  bus.mem_addr, base + 32'(4 * w));
            chk("fill_stall", 32'(bus.cpu_stall), 32'd1);
            tick();
            if (bus.inv) begin
              poison = 1'b1;
              m_clear();
            end
            bus.inv     = 1'b0;
            bus.mem_ack = 1'b0;
            cyc++;
          end
        end
      end
      if (!aborted && !poison) begin
        m_valid[a[7:4]] = 1'b1;
        m_tag[a[7:4]]   = a[31:8];
      end
    end
  endtask

  // Invalidate-all pulse while IDLE; leaves the bench mid-cycle in IDLE.
  task automatic inv_idle(input logic [31:0] a);
    bus.cpu_addr = a;
    bus.inv      = 1'b1;
    bus.mem_ack  = 1'b0;
    #2;
    chk("inv_stall", 32'(bus.cpu_stall), m_hit(a) ? 32'd0 : 32'd1);
    tick();
    bus.inv = 1'b0;
    m_clear();
    #2;
    chk("inv_nofill", 32'(bus.mem_req), 32'd0);
    chk("inv_allgone", 32'(bus.cpu_stall), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    m_clear();
    reset        = 1'b0;
    bus.cpu_addr = 32'h100;
    bus.inv      = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    #3;
    chk("reset_stall", 32'(bus.cpu_stall), 32'd1);
    chk("reset_req",   32'(bus.mem_req), 32'd0);
    chk("reset_addr",  bus.mem_addr, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed scenarios.
    access(32'h100, 0, -1, -1, 1'b0);   // cold miss, ack every cycle
    access(32'h108, 0, -1, -1, 1'b0);   // hit in same line
    access(32'h500, 0, -1, -1, 1'b0);   // conflict evicts 0x100
    access(32'h100, 0, -1, -1, 1'b0);   // 0x100 misses again
    access(32'h304, -3, -1, -1, 1'b0);  // 3-cycle ack latency
    access(32'h200, 0, 2, -1, 1'b0);    // inv mid-fill, re-miss
    access(32'h20C, 0, 3, -1, 1'b0);    // inv on the final ack
    access(32'h240, 1, -1, 2, 1'b0);    // reset mid-fill, stray ack after
    inv_idle(32'h240);
    access(32'h244, 0, -1, -1, 1'b0);

    // Randomized mix over a small address pool to get plenty of hits.
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        inv_idle(a);
      end else begin
        access(a, int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1,
               ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1,
               1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_icache_dm
`default_nettype wire
